// File: rtl/alu_op_decoder.sv
// RV32I decode stage: R-type ALU, I-type ALU and LUI into a registered ALU control bundle.
// Optional: define DECODE_HALT_ON_ILLEGAL_EN to park in HALT after an illegal instruction until flush.
module alu_op_decoder #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_inst,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [3:0]      alu_decode,
   output logic [4:0]      rs1_addr,
   output logic [4:0]      rs2_addr,
   output logic [4:0]      rd_addr,
   output logic            rd_we,
   output logic            use_imm,
   output logic [XLEN-1:0] imm,
   output logic            illegal
);

   localparam logic [3:0] OP_AND  = 4'd0;
   localparam logic [3:0] OP_OR   = 4'd1;
   localparam logic [3:0] OP_ADD  = 4'd2;
   localparam logic [3:0] OP_SUB  = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SLL  = 4'd5;
   localparam logic [3:0] OP_SRL  = 4'd6;
   localparam logic [3:0] OP_SLT  = 4'd7;
   localparam logic [3:0] OP_SLTU = 4'd8;
   localparam logic [3:0] OP_SRA  = 4'd9;

   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] F7_ALT    = 7'b0100000;

   typedef enum logic [1:0] {S_EMPTY, S_FULL, S_HALT} state_t;

   typedef struct packed {
      logic [3:0]      op;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic            we;
      logic            use_imm;
      logic [XLEN-1:0] imm;
      logic            illegal;
   } bundle_t;

   state_t  state_q, state_d;
   bundle_t bundle_q, bundle_d;
   bundle_t dec;

   logic [6:0]      opcode, funct7;
   logic [2:0]      funct3;
   logic            legal, rs1_used, rs2_used, imm_sel;
   logic [3:0]      op;
   logic [XLEN-1:0] imm_v;
   logic            capture;

   assign opcode = in_inst[6:0];
   assign funct3 = in_inst[14:12];
   assign funct7 = in_inst[31:25];

   always_comb begin
      legal    = 1'b0;
      op       = OP_ADD;
      imm_v    = '0;
      imm_sel  = 1'b0;
      rs1_used = 1'b1;
      rs2_used = 1'b0;
      case (opcode)
         OPC_OP: begin
            rs2_used = 1'b1;
            if (funct7 == 7'b0) begin
               legal = 1'b1;
               case (funct3)
                  3'b000: op = OP_ADD;
                  3'b001: op = OP_SLL;
                  3'b010: op = OP_SLT;
                  3'b011: op = OP_SLTU;
                  3'b100: op = OP_XOR;
                  3'b101: op = OP_SRL;
                  3'b110: op = OP_OR;
                  3'b111: op = OP_AND;
               endcase
            end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
               legal = 1'b1;
               op    = OP_SUB;
            end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
               legal = 1'b1;
               op    = OP_SRA;
            end
         end
         OPC_OPIMM: begin
            imm_sel = 1'b1;
            imm_v   = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
            case (funct3)
               3'b000: begin legal = 1'b1; op = OP_ADD;  end
               3'b010: begin legal = 1'b1; op = OP_SLT;  end
               3'b011: begin legal = 1'b1; op = OP_SLTU; end
               3'b100: begin legal = 1'b1; op = OP_XOR;  end
               3'b110: begin legal = 1'b1; op = OP_OR;   end
               3'b111: begin legal = 1'b1; op = OP_AND;  end
               3'b001: begin
                  legal = (funct7 == 7'b0);
                  op    = OP_SLL;
                  imm_v = {{(XLEN-5){1'b0}}, in_inst[24:20]};
               end
               3'b101: begin
                  legal = (funct7 == 7'b0) || (funct7 == F7_ALT);
                  op    = funct7[5] ? OP_SRA : OP_SRL;
                  imm_v = {{(XLEN-5){1'b0}}, in_inst[24:20]};
               end
            endcase
         end
         OPC_LUI: begin
            legal    = 1'b1;
            imm_sel  = 1'b1;
            rs1_used = 1'b0;
            imm_v    = {in_inst[31:12], {(XLEN-20){1'b0}}};
         end
         default: ;
      endcase
   end

   // Illegal words collapse to a harmless ADD with no writeback and zeroed fields.
   always_comb begin
      dec    = '0;
      dec.op = OP_ADD;
      if (legal) begin
         dec.op      = op;
         dec.rs1     = rs1_used ? in_inst[19:15] : 5'd0;
         dec.rs2     = rs2_used ? in_inst[24:20] : 5'd0;
         dec.rd      = in_inst[11:7];
         dec.we      = |in_inst[11:7];
         dec.use_imm = imm_sel;
         dec.imm     = imm_v;
      end else begin
         dec.illegal = 1'b1;
      end
   end

   assign in_ready = !flush && ((state_q == S_EMPTY) || (state_q == S_FULL && out_ready));
   assign capture  = in_valid && in_ready;

   always_comb begin
      state_d  = state_q;
      bundle_d = bundle_q;
      if (flush) begin
         state_d = S_EMPTY;
      end else if (capture) begin
         bundle_d = dec;
`ifdef DECODE_HALT_ON_ILLEGAL_EN
         state_d  = dec.illegal ? S_HALT : S_FULL;
`else
         state_d  = S_FULL;
`endif
      end else if (state_q == S_FULL && out_ready) begin
         state_d = S_EMPTY;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_EMPTY;
         bundle_q <= '0;
      end else begin
         state_q  <= state_d;
         bundle_q <= bundle_d;
      end
   end

   assign out_valid  = (state_q != S_EMPTY);
   assign alu_decode = bundle_q.op;
   assign rs1_addr   = bundle_q.rs1;
   assign rs2_addr   = bundle_q.rs2;
   assign rd_addr    = bundle_q.rd;
   assign rd_we      = bundle_q.we;
   assign use_imm    = bundle_q.use_imm;
   assign imm        = bundle_q.imm;
   assign illegal    = bundle_q.illegal;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Bench for alu_op_decoder (default build): directed test-plan cases plus random traffic vs a table-driven model.
module tb_alu_op_decoder;

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, out_ready;
   logic        in_ready, out_valid, rd_we, use_imm, illegal;
   logic [31:0] in_inst, imm;
   logic [3:0]  alu_decode;
   logic [4:0]  rs1_addr, rs2_addr, rd_addr;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [3:0]  op;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        we;
      logic        use_imm;
      logic [31:0] imm;
      logic        ill;
   } bundle_t;

   // Instruction tables: R-type keyed by {funct7,funct3}, I-type arithmetic keyed by funct3.
   logic [9:0] r_key [10];
   logic [3:0] r_op  [10];
   logic [2:0] i_key [6];
   logic [3:0] i_op  [6];

   logic    m_full;
   bundle_t m_b;

   always #5 clk = ~clk;

   alu_op_decoder #(.XLEN(32)) dut (
      .clk(clk), .reset(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
      .out_valid(out_valid), .out_ready(out_ready),
      .alu_decode(alu_decode), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rd_addr(rd_addr), .rd_we(rd_we), .use_imm(use_imm), .imm(imm), .illegal(illegal)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bundle_t ref_decode(input logic [31:0] w);
      bundle_t b;
      logic    ok;
      logic [3:0] o;
      logic [31:0] iv;
      logic [4:0] r1, r2;
      ok = 1'b0; o = 4'd2; iv = 32'd0; r1 = w[19:15]; r2 = 5'd0;
      if (w[6:0] == 7'h33) begin
         r2 = w[24:20];
         for (int k = 0; k < 10; k++)
            if (r_key[k] == {w[31:25], w[14:12]}) begin ok = 1'b1; o = r_op[k]; end
      end else if (w[6:0] == 7'h13) begin
         iv = 32'($signed(w[31:20]));
         for (int k = 0; k < 6; k++)
            if (i_key[k] == w[14:12]) begin ok = 1'b1; o = i_op[k]; end
         if (w[14:12] == 3'd1 && w[31:25] == 7'h00) begin ok = 1'b1; o = 4'd5; iv = 32'(w[24:20]); end
         if (w[14:12] == 3'd5 && w[31:25] == 7'h00) begin ok = 1'b1; o = 4'd6; iv = 32'(w[24:20]); end
         if (w[14:12] == 3'd5 && w[31:25] == 7'h20) begin ok = 1'b1; o = 4'd9; iv = 32'(w[24:20]); end
      end else if (w[6:0] == 7'h37) begin
         ok = 1'b1; r1 = 5'd0; iv = w & 32'hFFFFF000;
      end
      b = '0;
      b.op = 4'd2;
      if (ok) begin
         b.op = o; b.rs1 = r1; b.rs2 = r2; b.rd = w[11:7];
         b.we = (w[11:7] != 5'd0); b.use_imm = (w[6:0] != 7'h33); b.imm = iv;
      end else begin
         b.ill = 1'b1;
      end
      return b;
   endfunction

   function automatic logic [31:0] rand_inst();
      logic [31:0] w;
      logic [6:0]  f7;
      int sel;
      w   = $urandom;
      sel = $urandom_range(0, 5);
      case ($urandom_range(0, 2))
         0: f7 = 7'h00;
         1: f7 = 7'h20;
         default: f7 = 7'($urandom);
      endcase
      case (sel)
         0, 1: w = {f7, w[24:7], 7'h33};
         2, 3: w = {(($urandom_range(0, 1) == 1) ? f7 : w[31:25]), w[24:7], 7'h13};
         4:    w = {w[31:7], 7'h37};
         default: ;
      endcase
      return w;
   endfunction

   function automatic bundle_t dut_bundle();
      return {alu_decode, rs1_addr, rs2_addr, rd_addr, rd_we, use_imm, imm, illegal};
   endfunction

   // One clock: drive at posedge+1, check in_ready, update the model at the edge, check outputs after it.
   task automatic step(input logic v, input logic [31:0] w, input logic ordy, input logic fl);
      logic exp_ready;
      in_valid = v; in_inst = w; out_ready = ordy; flush = fl;
      #1;
      exp_ready = !fl && (!m_full || ordy);
      check("in_ready", 64'(in_ready), 64'(exp_ready));
      @(posedge clk);
      if (fl) m_full = 1'b0;
      else if (v && exp_ready) begin m_full = 1'b1; m_b = ref_decode(w); end
      else if (m_full && ordy) m_full = 1'b0;
      #1;
      check("out_valid", 64'(out_valid), 64'(m_full));
      check("bundle", 64'(dut_bundle()), 64'(m_b));
      $display("cyc v=%0b inst=%08h ordy=%0b fl=%0b -> out_valid=%0b op=%0d imm=%08h ill=%0b",
               v, w, ordy, fl, out_valid, alu_decode, imm, illegal);
   endtask

   initial begin
      int vcount;
      r_key[0] = {7'h00, 3'd0}; r_op[0] = 4'd2;
      r_key[1] = {7'h20, 3'd0}; r_op[1] = 4'd3;
      r_key[2] = {7'h00, 3'd1}; r_op[2] = 4'd5;
      r_key[3] = {7'h00, 3'd2}; r_op[3] = 4'd7;
      r_key[4] = {7'h00, 3'd3}; r_op[4] = 4'd8;
      r_key[5] = {7'h00, 3'd4}; r_op[5] = 4'd4;
      r_key[6] = {7'h00, 3'd5}; r_op[6] = 4'd6;
      r_key[7] = {7'h20, 3'd5}; r_op[7] = 4'd9;
      r_key[8] = {7'h00, 3'd6}; r_op[8] = 4'd1;
      r_key[9] = {7'h00, 3'd7}; r_op[9] = 4'd0;
      i_key[0] = 3'd0; i_op[0] = 4'd2;
      i_key[1] = 3'd2; i_op[1] = 4'd7;
      i_key[2] = 3'd3; i_op[2] = 4'd8;
      i_key[3] = 3'd4; i_op[3] = 4'd4;
      i_key[4] = 3'd6; i_op[4] = 4'd1;
      i_key[5] = 3'd7; i_op[5] = 4'd0;
      m_full = 1'b0; m_b = '0;

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_inst = '0;
      #2;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_bundle", 64'(dut_bundle()), 64'd0);
      @(posedge clk); @(posedge clk);
      #1 rst_n = 1'b1;

      // Test-plan decodes
      step(1'b1, 32'h002081B3, 1'b1, 1'b0);
      check("add_op", 64'(alu_decode), 64'd2);
      check("add_regs", 64'({rs1_addr, rs2_addr, rd_addr, rd_we, use_imm, illegal}),
            64'({5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0}));
      step(1'b1, 32'h402081B3, 1'b1, 1'b0);
      check("sub_op", 64'(alu_decode), 64'd3);
      step(1'b1, 32'h40735293, 1'b1, 1'b0);
      check("srai", 64'({alu_decode, rs1_addr, rd_addr, use_imm, imm}),
            64'({4'd9, 5'd6, 5'd5, 1'b1, 32'h7}));
      step(1'b1, 32'hFFF00093, 1'b1, 1'b0);
      check("addi_imm", 64'({alu_decode, imm}), 64'({4'd2, 32'hFFFFFFFF}));
      step(1'b1, 32'h123453B7, 1'b1, 1'b0);
      check("lui", 64'({imm, rs1_addr, rd_addr}), 64'({32'h12345000, 5'd0, 5'd7}));

      // Backpressure: bundle holds, in_ready stays low
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 32'h00000013, 1'b0, 1'b0);
         check("bp_hold_imm", 64'(imm), 64'h12345000);
      end
      vcount = 0;
      for (int k = 0; k < 4; k++) begin
         step(1'b1, 32'h00100093 + (32'(k) << 20), 1'b1, 1'b0);
         if (out_valid) vcount++;
      end
      check("stream_count", 64'(vcount), 64'd4);
      check("stream_last_imm", 64'(imm), 64'd4);
      step(1'b0, 32'h0, 1'b1, 1'b0);

      // Illegal word flows through like a normal instruction
      step(1'b1, 32'h00000000, 1'b0, 1'b0);
      check("illegal", 64'({illegal, rd_we}), 64'({1'b1, 1'b0}));
      step(1'b1, 32'h002081B3, 1'b1, 1'b0);
      step(1'b1, 32'h00000013, 1'b0, 1'b1);
      check("flush_drop", 64'(out_valid), 64'd0);

      // Asynchronous reset while FULL
      step(1'b1, 32'h002081B3, 1'b0, 1'b0);
      #3 rst_n = 1'b0;
      #1;
      check("async_rst_valid", 64'(out_valid), 64'd0);
      check("async_rst_bundle", 64'(dut_bundle()), 64'd0);
      m_full = 1'b0; m_b = '0;
      @(posedge clk);
      #1 rst_n = 1'b1;

      for (int k = 0; k < 2000; k++)
         step($urandom_range(0, 3) != 0, rand_inst(), $urandom_range(0, 3) != 0,
              $urandom_range(0, 15) == 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
